// File: rtl/cpu7_ifu_fbuf.sv
// cpu7_ifu_fbuf: credit-throttled ICU fetch sequencer and circular instruction queue feeding decode
module cpu7_ifu_fbuf #(
  parameter int FETCH_INSTS = 2,
  parameter int DEPTH = 8,
  parameter int CW = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               pc_init,
  input  logic                      redirect_vld,
  input  logic [31:0]               redirect_pc,
  output logic                      ifu_icu_req_ic1,
  output logic [31:0]               ifu_icu_addr_ic1,
  input  logic                      icu_ifu_ack_ic1,
  output logic                      ifu_icu_cancel,
  input  logic [32*FETCH_INSTS-1:0] icu_ifu_data_ic2,
  input  logic                      icu_ifu_data_valid_ic2,
  output logic                      fbuf_dec_vld_f,
  output logic [31:0]               fbuf_dec_inst_f,
  output logic [31:0]               fbuf_dec_pc_f,
  input  logic                      dec_fbuf_take,
  output logic [CW-1:0]             fbuf_count
);
  localparam int LB = 4 * FETCH_INSTS;
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state;
  logic [31:0] fpc, rpc, k, line_rpc;
  logic [31:0] inst_q [DEPTH];
  logic [31:0] pc_q [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count, nwr;
  logic wr, take, ack, credit;
  assign k = (rpc >> 2) & 32'(FETCH_INSTS - 1);
  assign line_rpc = rpc & ~32'(LB - 1);
  assign nwr = CW'(32'(FETCH_INSTS) - k);
  assign credit = count <= CW'(DEPTH - FETCH_INSTS);
  assign wr = state == WAIT && icu_ifu_data_valid_ic2 && !redirect_vld;
  assign take = dec_fbuf_take && count != '0;
  assign ack = state == REQ && icu_ifu_ack_ic1 && !redirect_vld;
  assign ifu_icu_req_ic1 = state == REQ && !redirect_vld && !reset;
  assign ifu_icu_addr_ic1 = fpc & ~32'(LB - 1);
  // A same-cycle ack on a withdrawn request still needs the ICU told to drop it
  assign ifu_icu_cancel = !reset && redirect_vld && (state == WAIT || (state == REQ && icu_ifu_ack_ic1));
  assign fbuf_dec_vld_f = count != '0 && !reset;
  assign fbuf_dec_inst_f = fbuf_dec_vld_f ? inst_q[rd_ptr] : '0;
  assign fbuf_dec_pc_f = fbuf_dec_vld_f ? pc_q[rd_ptr] : '0;
  assign fbuf_count = count;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fpc <= pc_init;
      rpc <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (redirect_vld) begin
      state <= IDLE;
      fpc <= redirect_pc;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (take) rd_ptr <= rd_ptr + PW'(1);
      if (wr) wr_ptr <= wr_ptr + PW'(nwr);
      if (wr) assert (32'(count) + 32'(nwr) <= DEPTH);
      count <= count + (wr ? nwr : '0) - CW'(take);
      state <= (state == IDLE && credit) ? REQ : ack ? WAIT : wr ? IDLE : state;
      if (ack) begin
        rpc <= fpc;
        fpc <= (fpc & ~32'(LB - 1)) + 32'(LB);
      end
    end
  end
  // Slots below the entry offset k of an unaligned fetch are skipped, not written
  always_ff @(posedge clk)
    for (int i = 0; i < FETCH_INSTS; i++)
      if (wr && 32'(i) >= k) begin
        inst_q[wr_ptr + PW'(32'(i) - k)] <= icu_ifu_data_ic2[32*i +: 32];
        pc_q[wr_ptr + PW'(32'(i) - k)] <= line_rpc + 32'(4 * i);
      end
endmodule

// File: tb/tb_cpu7_ifu_fbuf.sv
// tb_cpu7_ifu_fbuf: directed scoreboard bench for the fetch buffer, default and 4-wide/16-deep
module tb_cpu7_ifu_fbuf;
  typedef struct packed {logic [31:0] pc; logic [31:0] inst;} ent_t;
  logic clk = 0;
  always #5 clk = ~clk;
  logic reset, redirect_vld, ack, dv, take, req, cancel, vld;
  logic [31:0] pc_init, redirect_pc, addr, inst, pc;
  logic [63:0] data;
  logic [3:0] count;
  logic reset4, redirect4, ack4, dv4, take4, req4, cancel4, vld4;
  logic [31:0] pc_init4, redirect_pc4, addr4, inst4, pc4;
  logic [127:0] data4;
  logic [4:0] count4;
  ent_t q[$];
  ent_t q4[$];
  int total = 0, bad = 0;

  cpu7_ifu_fbuf dut (
    .clk(clk), .reset(reset), .pc_init(pc_init), .redirect_vld(redirect_vld), .redirect_pc(redirect_pc),
    .ifu_icu_req_ic1(req), .ifu_icu_addr_ic1(addr), .icu_ifu_ack_ic1(ack), .ifu_icu_cancel(cancel),
    .icu_ifu_data_ic2(data), .icu_ifu_data_valid_ic2(dv), .fbuf_dec_vld_f(vld), .fbuf_dec_inst_f(inst),
    .fbuf_dec_pc_f(pc), .dec_fbuf_take(take), .fbuf_count(count));

  cpu7_ifu_fbuf #(.FETCH_INSTS(4), .DEPTH(16)) dut4 (
    .clk(clk), .reset(reset4), .pc_init(pc_init4), .redirect_vld(redirect4), .redirect_pc(redirect_pc4),
    .ifu_icu_req_ic1(req4), .ifu_icu_addr_ic1(addr4), .icu_ifu_ack_ic1(ack4), .ifu_icu_cancel(cancel4),
    .icu_ifu_data_ic2(data4), .icu_ifu_data_valid_ic2(dv4), .fbuf_dec_vld_f(vld4), .fbuf_dec_inst_f(inst4),
    .fbuf_dec_pc_f(pc4), .dec_fbuf_take(take4), .fbuf_count(count4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i);
    ent_t e;
    e.pc = p;
    e.inst = i;
    q.push_back(e);
  endtask

  task automatic take_one();
    ent_t e;
    take = 1;
    chk("head_vld", vld, 1);
    if (q.size() == 0) chk("sb_empty", 0, 1);
    else begin
      e = q.pop_front();
      chk("head_pc", pc, e.pc);
      chk("head_inst", inst, e.inst);
    end
  endtask

  task automatic take_step();
    take_one();
    tick();
    take = 0;
  endtask

  task automatic wait_req();
    int n = 0;
    while (!req && n < 20) begin
      tick();
      n++;
    end
    chk("req_wait", req, 1);
  endtask

  task automatic fetch_line(input int k, input logic [31:0] i0, input logic [31:0] i1);
    logic [31:0] a;
    wait_req();
    a = addr;
    ack = 1;
    tick();
    ack = 0;
    dv = 1;
    data = {i1, i0};
    if (k == 0) push(a, i0);
    push(a + 4, i1);
    tick();
    dv = 0;
  endtask

  initial begin
    ent_t e;
    int lines, acked, pend, lat;
    logic [31:0] exp_line, pend_line;
    reset = 1; pc_init = 32'h1c000000; redirect_vld = 0; redirect_pc = 0; ack = 0; dv = 0; data = 0; take = 0;
    reset4 = 1; pc_init4 = 32'h1c001000; redirect4 = 0; redirect_pc4 = 0; ack4 = 0; dv4 = 0; data4 = 0; take4 = 0;
    // reset boot
    repeat (3) tick();
    chk("rst_req", req, 0);
    chk("rst_vld", vld, 0);
    chk("rst_count", count, 0);
    chk("rst_cancel", cancel, 0);
    reset = 0;
    #1 chk("boot_req_early", req, 0);
    tick();
    chk("boot_req", req, 1);
    chk("boot_addr", addr, 32'h1c000000);
    fetch_line(0, 32'h02800400, 32'h02800421);
    chk("boot_count2", count, 2);
    take_step();
    chk("boot_count1", count, 1);
    take_step();
    chk("boot_count0", count, 0);
    chk("boot_vld0", vld, 0);
    wait_req();
    chk("boot_next_addr", addr, 32'h1c000008);
    // credit stall
    for (int n = 0; n < 4; n++) fetch_line(0, 32'h1000 + 32'(2 * n), 32'h1001 + 32'(2 * n));
    chk("cr_count8", count, 8);
    repeat (2) begin
      chk("cr_noreq8", req, 0);
      tick();
    end
    take_step();
    chk("cr_count7", count, 7);
    chk("cr_noreq7", req, 0);
    tick();
    chk("cr_noreq7b", req, 0);
    take_step();
    chk("cr_count6", count, 6);
    chk("cr_noreq6", req, 0);
    tick();
    chk("cr_req6", req, 1);
    chk("cr_addr", addr, 32'h1c000028);
    repeat (6) take_step();
    chk("cr_drained", count, 0);
    // unaligned redirect while a request is pending without ack
    redirect_vld = 1; redirect_pc = 32'h1c000104;
    #1 chk("ur_cancel0", cancel, 0);
    chk("ur_req_withdrawn", req, 0);
    tick();
    redirect_vld = 0;
    #1 chk("ur_req_idle", req, 0);
    tick();
    chk("ur_req", req, 1);
    chk("ur_addr", addr, 32'h1c000100);
    fetch_line(1, 32'hdead0000, 32'h02800421);
    chk("ur_count1", count, 1);
    take_step();
    wait_req();
    chk("ur_next_addr", addr, 32'h1c000108);
    // redirect on a same-cycle ack
    ack = 1; redirect_vld = 1; redirect_pc = 32'h1c000200;
    #1 chk("ra_cancel", cancel, 1);
    chk("ra_req", req, 0);
    tick();
    ack = 0; redirect_vld = 0;
    #1 chk("ra_cancel_off", cancel, 0);
    chk("ra_count", count, 0);
    // cancel while waiting, with data in the same cycle
    wait_req();
    chk("cw_addr", addr, 32'h1c000200);
    ack = 1;
    tick();
    ack = 0; redirect_vld = 1; redirect_pc = 32'h1c000300; dv = 1; data = 64'h11112222_33334444;
    #1 chk("cw_cancel", cancel, 1);
    tick();
    redirect_vld = 0; dv = 0;
    #1 chk("cw_cancel_off", cancel, 0);
    chk("cw_count", count, 0);
    chk("cw_vld", vld, 0);
    chk("cw_req_t1", req, 0);
    tick();
    chk("cw_req_t2", req, 1);
    chk("cw_addr_new", addr, 32'h1c000300);
    // simultaneous write and take at count 3
    fetch_line(0, 32'h300, 32'h304);
    fetch_line(0, 32'h308, 32'h30c);
    wait_req();
    ack = 1;
    take_one();
    tick();
    ack = 0; take = 0;
    chk("wt_count3", count, 3);
    dv = 1; data = {32'h314, 32'h310};
    push(32'h1c000310, 32'h310);
    push(32'h1c000314, 32'h314);
    take_one();
    tick();
    dv = 0; take = 0;
    chk("wt_count4", count, 4);
    chk("wt_head", pc, 32'h1c000308);
    repeat (4) take_step();
    chk("wt_drained", count, 0);
    // reset in the middle of a wait, late data ignored
    wait_req();
    ack = 1;
    tick();
    ack = 0; reset = 1; pc_init = 32'h1c000800;
    tick();
    chk("rw_vld", vld, 0);
    chk("rw_count", count, 0);
    chk("rw_req", req, 0);
    dv = 1; data = 64'h55556666_77778888;
    tick();
    dv = 0;
    chk("rw_late_count", count, 0);
    chk("rw_late_vld", vld, 0);
    reset = 0;
    #1 chk("rw_req_rel", req, 0);
    tick();
    chk("rw_req_new", req, 1);
    chk("rw_addr_new", addr, 32'h1c000800);
    chk("rw_count_new", count, 0);
    reset = 1;
    // 4-wide, 16-deep stream through pointer wrap with random take
    repeat (2) tick();
    reset4 = 0;
    lines = 0; acked = 0; pend = 0; lat = 0; exp_line = 32'h1c001000; pend_line = 0;
    for (int cyc = 0; cyc < 5000 && !(lines == 100 && q4.size() == 0); cyc++) begin
      chk("w_count", count4, q4.size());
      ack4 = 0; dv4 = 0;
      if (pend != 0) begin
        if (lat == 0) begin
          dv4 = 1;
          for (int i = 0; i < 4; i++) begin
            data4[32*i +: 32] = ~(pend_line + 32'(4 * i));
            e.pc = pend_line + 32'(4 * i);
            e.inst = ~(pend_line + 32'(4 * i));
            q4.push_back(e);
          end
          pend = 0;
          lines++;
        end else lat--;
      end else if (req4 && acked < 100) begin
        chk("w_addr", addr4, exp_line);
        ack4 = 1;
        pend = 1;
        pend_line = exp_line;
        lat = int'($urandom_range(0, 2));
        exp_line += 16;
        acked++;
      end
      take4 = 1'($urandom_range(0, 1));
      if (take4 && vld4) begin
        if (q4.size() == 0) chk("w_sb_empty", 0, 1);
        else begin
          e = q4.pop_front();
          chk("w_pc", pc4, e.pc);
          chk("w_inst", inst4, e.inst);
        end
      end
      tick();
    end
    ack4 = 0; dv4 = 0; take4 = 0;
    chk("w_lines", 32'(lines), 100);
    chk("w_sb_left", 32'(q4.size()), 0);
    chk("w_cancel", cancel4, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
